uart_baud_tick_gen: RTL

//  Parametrised baud-rate generator; successor to the fixed-count 1.8432 MHz divider.

---
 rtl/uart_baud_tick_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_baud_tick_gen.sv
// Baud-rate generator: runtime-loadable divisor producing oversample tick, baud tick and baud clock.
// Optional fractional divisor built when UART_BAUD_FRAC_EN is defined.
module uart_baud_tick_gen #(
    parameter int unsigned DIV_W          = 16,
    parameter int unsigned FRAC_W         = 4,
    parameter int unsigned OVS            = 16,
    parameter int unsigned RESET_DIV_INT  = 55,
    parameter int unsigned RESET_DIV_FRAC = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    output logic                    div_pending,
    output logic                    ovs_tick,
    output logic                    baud_tick,
    output logic [$clog2(OVS)-1:0]  ovs_phase,
    output logic                    clk_out
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned PH_W  = $clog2(OVS);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_int_act_q, div_int_act_d;
    logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
    logic              pending_q, pending_d;
    logic              ovs_tick_q, ovs_tick_d;
    logic              baud_tick_q, baud_tick_d;
    logic [PH_W-1:0]   ovs_phase_q, ovs_phase_d;
    logic              clk_out_q, clk_out_d;

    logic              extra_c;
    logic [CNT_W-1:0]  d_eff_c;
    logic [CNT_W-1:0]  period_m1_c;
    logic              boundary_c;
    logic [PH_W-1:0]   phase_next_c;

    // Divisor update decisions shared by the integer and fractional paths
    logic              load_idle_c;
    logic              load_bypass_c;
    logic              apply_shadow_c;
    logic              capture_c;

    always_comb begin
        d_eff_c        = (div_int_act_q == '0) ? CNT_W'(1) : CNT_W'(div_int_act_q);
        period_m1_c    = d_eff_c - CNT_W'(1) + CNT_W'(extra_c);
        boundary_c     = enable && (cnt_q == period_m1_c);
        phase_next_c   = (ovs_phase_q == PH_W'(OVS - 1)) ? '0 : ovs_phase_q + PH_W'(1);
        load_idle_c    = !enable && div_load;
        load_bypass_c  = boundary_c && div_load;
        apply_shadow_c = boundary_c && !div_load && pending_q;
        capture_c      = enable && !boundary_c && div_load;
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] div_frac_act_q, div_frac_act_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic [FRAC_W:0]   frac_sum_c;

    // The carry of this period's accumulation stretches this period by one clock
    always_comb begin
        frac_sum_c     = {1'b0, acc_q} + {1'b0, div_frac_act_q};
        extra_c        = frac_sum_c[FRAC_W];
        acc_d          = acc_q;
        div_frac_act_d = div_frac_act_q;
        shadow_frac_d  = shadow_frac_q;
        if (load_idle_c) begin
            acc_d          = '0;
            div_frac_act_d = div_frac;
        end else if (boundary_c) begin
            acc_d = frac_sum_c[FRAC_W-1:0];
            if (load_bypass_c) begin
                div_frac_act_d = div_frac;
            end else if (apply_shadow_c) begin
                div_frac_act_d = shadow_frac_q;
            end
        end else if (capture_c) begin
            shadow_frac_d = div_frac;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q          <= '0;
            div_frac_act_q <= FRAC_W'(RESET_DIV_FRAC);
            shadow_frac_q  <= '0;
        end else begin
            acc_q          <= acc_d;
            div_frac_act_q <= div_frac_act_d;
            shadow_frac_q  <= shadow_frac_d;
        end
    end
`else
    logic unused_frac_c;

    always_comb begin
        extra_c       = 1'b0;
        unused_frac_c = ^div_frac;
    end
`endif

    // Period counter, divisor shadowing and tick generation
    always_comb begin
        cnt_d         = cnt_q;
        div_int_act_d = div_int_act_q;
        shadow_int_d  = shadow_int_q;
        pending_d     = pending_q;
        ovs_tick_d    = 1'b0;
        baud_tick_d   = 1'b0;
        ovs_phase_d   = ovs_phase_q;
        clk_out_d     = clk_out_q;

        if (load_idle_c) begin
            // Loading while stopped restarts the whole baud period from scratch
            div_int_act_d = div_int;
            cnt_d         = '0;
            ovs_phase_d   = '0;
            clk_out_d     = 1'b0;
            pending_d     = 1'b0;
        end else if (boundary_c) begin
            cnt_d       = '0;
            ovs_tick_d  = 1'b1;
            baud_tick_d = (ovs_phase_q == PH_W'(OVS - 1));
            ovs_phase_d = phase_next_c;
            clk_out_d   = (phase_next_c >= PH_W'(OVS / 2));
            pending_d   = 1'b0;
            if (load_bypass_c) begin
                div_int_act_d = div_int;
            end else if (apply_shadow_c) begin
                div_int_act_d = shadow_int_q;
            end
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (capture_c) begin
                shadow_int_d = div_int;
                pending_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            div_int_act_q <= DIV_W'(RESET_DIV_INT);
            shadow_int_q  <= '0;
            pending_q     <= 1'b0;
            ovs_tick_q    <= 1'b0;
            baud_tick_q   <= 1'b0;
            ovs_phase_q   <= '0;
            clk_out_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_int_act_q <= div_int_act_d;
            shadow_int_q  <= shadow_int_d;
            pending_q     <= pending_d;
            ovs_tick_q    <= ovs_tick_d;
            baud_tick_q   <= baud_tick_d;
            ovs_phase_q   <= ovs_phase_d;
            clk_out_q     <= clk_out_d;
        end
    end

    assign div_pending = pending_q;
    assign ovs_tick    = ovs_tick_q;
    assign baud_tick   = baud_tick_q;
    assign ovs_phase   = ovs_phase_q;
    assign clk_out     = clk_out_q;

endmodule
